traffic_input_conditioner: RTL and testbench

//  Upstream front end of the intersection controller. Synchronises and debounces the raw

---
 rtl/traffic_input_conditioner.sv | 195 +++++++++++++++++++
 tb/tb_traffic_input_conditioner.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : traffic_input_conditioner
// Description : Synchronises/debounces pedestrian buttons into latched walk
//               requests and qualifies vehicle loops with arrival counting.
// Revision    : 1.0 - initial release
// ============================================================================

module traffic_input_conditioner #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int PRESENCE_MS = 500,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   raw_pd_btn_ns,
  input  logic                   raw_pd_btn_ew,
  input  logic                   raw_sensor_ns,
  input  logic                   raw_sensor_ew,
  input  logic                   pd_serviced_ns,
  input  logic                   pd_serviced_ew,
  input  logic                   count_clr,
  output logic                   pd_button_ns,
  output logic                   pd_button_ew,
  output logic                   ns_sensor,
  output logic                   ew_sensor,
  output logic [COUNT_WIDTH-1:0] veh_count_ns,
  output logic [COUNT_WIDTH-1:0] veh_count_ew
);

  localparam int DB_RAW = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int PR_RAW = CLK_FREQ / 1000 * PRESENCE_MS;
  localparam int DB_CYC = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int PR_CYC = (PR_RAW < 1) ? 1 : PR_RAW;

  // The sample that moves a button out of a stable state is the first of the
  // DB_CYC required, so the confirm counter only needs to reach DB_CYC-2.
  localparam bit          DB_SHORT = (DB_CYC < 2);
  localparam logic [31:0] DB_LIM   = DB_SHORT ? 32'd0 : 32'(DB_CYC - 2);
  localparam logic [31:0] PR_LIM   = 32'(PR_CYC - 1);

  localparam logic [COUNT_WIDTH-1:0] VCNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] VCNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    BTN_RELEASED        = 2'd0,
    BTN_CONFIRM_PRESS   = 2'd1,
    BTN_PRESSED         = 2'd2,
    BTN_CONFIRM_RELEASE = 2'd3
  } btn_state_e;

  logic [1:0] w_btn_raw;
  logic [1:0] w_sen_raw;
  logic [1:0] w_srv;

  assign w_btn_raw = {raw_pd_btn_ew, raw_pd_btn_ns};
  assign w_sen_raw = {raw_sensor_ew, raw_sensor_ns};
  assign w_srv     = {pd_serviced_ew, pd_serviced_ns};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic                   btn_meta_q, btn_sync_q;
    logic                   sen_meta_q, sen_sync_q;
    btn_state_e             btn_state_q, btn_state_d;
    logic [31:0]            btn_cnt_q, btn_cnt_d;
    logic                   press_evt;
    logic                   req_q, req_d;
    logic [31:0]            pr_cnt_q, pr_cnt_d;
    logic                   pres_q, pres_d;
    logic                   pres_prev_q;
    logic [COUNT_WIDTH-1:0] vcnt_q, vcnt_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        btn_meta_q  <= 1'b0;
        btn_sync_q  <= 1'b0;
        sen_meta_q  <= 1'b0;
        sen_sync_q  <= 1'b0;
        btn_state_q <= BTN_RELEASED;
        btn_cnt_q   <= 32'd0;
        req_q       <= 1'b0;
        pr_cnt_q    <= 32'd0;
        pres_q      <= 1'b0;
        pres_prev_q <= 1'b0;
        vcnt_q      <= '0;
      end else begin
        btn_meta_q  <= w_btn_raw[gi];
        btn_sync_q  <= btn_meta_q;
        sen_meta_q  <= w_sen_raw[gi];
        sen_sync_q  <= sen_meta_q;
        btn_state_q <= btn_state_d;
        btn_cnt_q   <= btn_cnt_d;
        req_q       <= req_d;
        pr_cnt_q    <= pr_cnt_d;
        pres_q      <= pres_d;
        pres_prev_q <= pres_q;
        vcnt_q      <= vcnt_d;
      end
    end

    always_comb begin
      btn_state_d = btn_state_q;
      btn_cnt_d   = btn_cnt_q;
      press_evt   = 1'b0;
      case (btn_state_q)
        BTN_RELEASED: begin
          if (btn_sync_q) begin
            btn_cnt_d = 32'd0;
            if (DB_SHORT) begin
              btn_state_d = BTN_PRESSED;
              press_evt   = 1'b1;
            end else begin
              btn_state_d = BTN_CONFIRM_PRESS;
            end
          end
        end
        BTN_CONFIRM_PRESS: begin
          if (!btn_sync_q) begin
            btn_state_d = BTN_RELEASED;
            btn_cnt_d   = 32'd0;
          end else if (btn_cnt_q >= DB_LIM) begin
            btn_state_d = BTN_PRESSED;
            btn_cnt_d   = 32'd0;
            press_evt   = 1'b1;
          end else begin
            btn_cnt_d = btn_cnt_q + 32'd1;
          end
        end
        BTN_PRESSED: begin
          if (!btn_sync_q) begin
            btn_cnt_d   = 32'd0;
            btn_state_d = DB_SHORT ? BTN_RELEASED : BTN_CONFIRM_RELEASE;
          end
        end
        BTN_CONFIRM_RELEASE: begin
          if (btn_sync_q) begin
            btn_state_d = BTN_PRESSED;
            btn_cnt_d   = 32'd0;
          end else if (btn_cnt_q >= DB_LIM) begin
            btn_state_d = BTN_RELEASED;
            btn_cnt_d   = 32'd0;
          end else begin
            btn_cnt_d = btn_cnt_q + 32'd1;
          end
        end
        default: begin
          btn_state_d = BTN_RELEASED;
          btn_cnt_d   = 32'd0;
        end
      endcase
    end

    // Service wins over a press completing on the same edge.
    always_comb begin
      req_d = req_q;
      if (w_srv[gi]) begin
        req_d = 1'b0;
      end else if (press_evt) begin
        req_d = 1'b1;
      end
    end

    always_comb begin
      pres_d   = pres_q;
      pr_cnt_d = pr_cnt_q;
      if (sen_sync_q == pres_q) begin
        pr_cnt_d = 32'd0;
      end else if (pr_cnt_q >= PR_LIM) begin
        pres_d   = sen_sync_q;
        pr_cnt_d = 32'd0;
      end else begin
        pr_cnt_d = pr_cnt_q + 32'd1;
      end
    end

    always_comb begin
      vcnt_d = vcnt_q;
      if (count_clr) begin
        vcnt_d = '0;
      end else if (pres_q && !pres_prev_q && (vcnt_q != VCNT_MAX)) begin
        vcnt_d = vcnt_q + VCNT_ONE;
      end
    end
  end

  assign pd_button_ns = g_chan[0].req_q;
  assign pd_button_ew = g_chan[1].req_q;
  assign ns_sensor    = g_chan[0].pres_q;
  assign ew_sensor    = g_chan[1].pres_q;
  assign veh_count_ns = g_chan[0].vcnt_q;
  assign veh_count_ew = g_chan[1].vcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_input_conditioner
// Description : Directed plus randomized bench against a run-length model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_traffic_input_conditioner;

  localparam int CLK_FREQ    = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int PRESENCE_MS = 8;
  localparam int COUNT_WIDTH = 4;
  localparam int DB          = 4;
  localparam int PR          = 8;
  localparam int CMAX        = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] r_btn, r_sen, r_srv;
  logic       clr;
  logic       pd_button_ns, pd_button_ew, ns_sensor, ew_sensor;
  logic [COUNT_WIDTH-1:0] veh_count_ns, veh_count_ew;

  traffic_input_conditioner #(
    .CLK_FREQ   (CLK_FREQ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .PRESENCE_MS(PRESENCE_MS),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .raw_pd_btn_ns (r_btn[0]),
    .raw_pd_btn_ew (r_btn[1]),
    .raw_sensor_ns (r_sen[0]),
    .raw_sensor_ew (r_sen[1]),
    .pd_serviced_ns(r_srv[0]),
    .pd_serviced_ew(r_srv[1]),
    .count_clr     (clr),
    .pd_button_ns  (pd_button_ns),
    .pd_button_ew  (pd_button_ew),
    .ns_sensor     (ns_sensor),
    .ew_sensor     (ew_sensor),
    .veh_count_ns  (veh_count_ns),
    .veh_count_ew  (veh_count_ew)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: a level flips once the last N seen samples all disagree with it,
  // where "seen" is the raw input two edges late.
  bit bd1[2], bd2[2], blast[2], blev[2], mreq[2];
  bit sd1[2], sd2[2], slast[2], plev[2], pprev[2];
  int brun[2], srun[2], mcnt[2];
  int run_b[2], run_s[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      bd1[c] = 0; bd2[c] = 0; blast[c] = 0; blev[c] = 0; mreq[c] = 0; brun[c] = 0;
      sd1[c] = 0; sd2[c] = 0; slast[c] = 0; plev[c] = 0; pprev[c] = 0; srun[c] = 0;
      mcnt[c] = 0;
    end
  endfunction

  function automatic void model_step();
    if (!rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 2; c++) begin
      bit seen;
      bit press;
      seen = bd2[c]; bd2[c] = bd1[c]; bd1[c] = r_btn[c];
      brun[c] = (seen == blast[c]) ? brun[c] + 1 : 1;
      blast[c] = seen;
      press = 0;
      if (seen != blev[c] && brun[c] >= DB) begin
        blev[c] = seen;
        press   = seen;
      end
      if (r_srv[c]) mreq[c] = 0;
      else if (press) mreq[c] = 1;

      if (clr) mcnt[c] = 0;
      else if (plev[c] && !pprev[c] && mcnt[c] < CMAX) mcnt[c] = mcnt[c] + 1;
      pprev[c] = plev[c];

      seen = sd2[c]; sd2[c] = sd1[c]; sd1[c] = r_sen[c];
      srun[c] = (seen == slast[c]) ? srun[c] + 1 : 1;
      slast[c] = seen;
      if (seen != plev[c] && srun[c] >= PR) plev[c] = seen;
    end
  endfunction

  task automatic compare_all();
    check_eq("pd_button_ns", {31'd0, pd_button_ns}, {31'd0, mreq[0]});
    check_eq("pd_button_ew", {31'd0, pd_button_ew}, {31'd0, mreq[1]});
    check_eq("ns_sensor",    {31'd0, ns_sensor},    {31'd0, plev[0]});
    check_eq("ew_sensor",    {31'd0, ew_sensor},    {31'd0, plev[1]});
    check_eq("veh_count_ns", 32'(veh_count_ns),     32'(mcnt[0]));
    check_eq("veh_count_ew", 32'(veh_count_ew),     32'(mcnt[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic rand_drive();
    for (int c = 0; c < 2; c++) begin
      if (run_b[c] == 0) begin
        r_btn[c] = ~r_btn[c];
        run_b[c] = $urandom_range(1, 12);
      end
      run_b[c]--;
      if (run_s[c] == 0) begin
        r_sen[c] = ~r_sen[c];
        run_s[c] = $urandom_range(1, 20);
      end
      run_s[c]--;
      r_srv[c] = ($urandom_range(0, 9) == 0);
    end
    clr = ($urandom_range(0, 79) == 0);
    rst = ($urandom_range(0, 599) != 0);
  endtask

  initial begin
    bit found;
    rst = 1'b0; r_btn = 2'b00; r_sen = 2'b00; r_srv = 2'b00; clr = 1'b0;
    model_reset();
    ticks(3);
    rst = 1'b1;
    ticks(4);

    // Clean press: request at edge 6, held after release, cleared by service.
    r_btn[0] = 1'b1;
    ticks(5);
    check_eq("t1_edge5", {31'd0, pd_button_ns}, 32'd0);
    tick();
    check_eq("t1_edge6", {31'd0, pd_button_ns}, 32'd1);
    ticks(4);
    r_btn[0] = 1'b0;
    ticks(8);
    check_eq("t1_held", {31'd0, pd_button_ns}, 32'd1);
    r_srv[0] = 1'b1;
    tick();
    r_srv[0] = 1'b0;
    check_eq("t1_serviced", {31'd0, pd_button_ns}, 32'd0);

    // Bouncy EW press, then an isolated 3-cycle glitch.
    foreach (run_b[i]) run_b[i] = 0;
    begin
      logic [5:0] bounce;
      bounce = 6'b101101;
      for (int i = 5; i >= 0; i--) begin
        r_btn[1] = bounce[i];
        tick();
      end
    end
    ticks(4);
    check_eq("t2_pre", {31'd0, pd_button_ew}, 32'd0);
    tick();
    check_eq("t2_rise", {31'd0, pd_button_ew}, 32'd1);
    r_btn[1] = 1'b0;
    ticks(10);
    r_srv[1] = 1'b1;
    tick();
    r_srv[1] = 1'b0;
    r_btn[1] = 1'b1;
    ticks(3);
    r_btn[1] = 1'b0;
    ticks(10);
    check_eq("t2_glitch", {31'd0, pd_button_ew}, 32'd0);

    // Press completing during service is dropped; held button does not re-request.
    r_srv[0] = 1'b1;
    r_btn[0] = 1'b1;
    ticks(8);
    r_srv[0] = 1'b0;
    ticks(4);
    check_eq("t3_dropped", {31'd0, pd_button_ns}, 32'd0);
    r_btn[0] = 1'b0;
    ticks(8);
    r_btn[0] = 1'b1;
    ticks(6);
    check_eq("t3_repress", {31'd0, pd_button_ns}, 32'd1);
    r_btn[0] = 1'b0;
    ticks(8);

    // Presence: short run ignored, long run qualifies and counts.
    r_sen[0] = 1'b1;
    ticks(7);
    r_sen[0] = 1'b0;
    ticks(12);
    check_eq("t4_short", {31'd0, ns_sensor}, 32'd0);
    r_sen[0] = 1'b1;
    ticks(9);
    check_eq("t4_edge9", {31'd0, ns_sensor}, 32'd0);
    tick();
    check_eq("t4_edge10", {31'd0, ns_sensor}, 32'd1);
    tick();
    check_eq("t4_count", 32'(veh_count_ns), 32'd1);
    ticks(9);
    r_sen[0] = 1'b0;
    ticks(9);
    check_eq("t4_fall9", {31'd0, ns_sensor}, 32'd1);
    tick();
    check_eq("t4_fall10", {31'd0, ns_sensor}, 32'd0);

    // Saturation, then clear coinciding with an increment.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (17) begin
      r_sen[0] = 1'b1; ticks(10);
      r_sen[0] = 1'b0; ticks(10);
    end
    ticks(2);
    check_eq("t5_saturate", 32'(veh_count_ns), 32'd15);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    r_sen[0] = 1'b1; ticks(12);
    r_sen[0] = 1'b0; ticks(12);
    check_eq("t5_one", 32'(veh_count_ns), 32'd1);
    r_sen[0] = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (plev[0] && !pprev[0]) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        found = 1;
      end else begin
        tick();
      end
    end
    check_eq("t5_found", {31'd0, found}, 32'd1);
    check_eq("t5_clr_wins", 32'(veh_count_ns), 32'd0);
    r_sen[0] = 1'b0;
    ticks(12);

    // Asynchronous reset with live state, then full re-qualification.
    repeat (4) begin
      r_sen[0] = 1'b1; ticks(10);
      r_sen[0] = 1'b0; ticks(10);
    end
    r_sen[0] = 1'b1;
    r_btn[0] = 1'b1;
    ticks(12);
    check_eq("t6_pre_cnt", 32'(veh_count_ns), 32'd5);
    check_eq("t6_pre_req", {31'd0, pd_button_ns}, 32'd1);
    check_eq("t6_pre_sen", {31'd0, ns_sensor}, 32'd1);
    rst = 1'b0;
    #2;
    check_eq("t6_async_req", {31'd0, pd_button_ns}, 32'd0);
    check_eq("t6_async_sen", {31'd0, ns_sensor}, 32'd0);
    check_eq("t6_async_cnt", 32'(veh_count_ns), 32'd0);
    model_reset();
    ticks(2);
    rst = 1'b1;
    ticks(5);
    check_eq("t6_req_edge5", {31'd0, pd_button_ns}, 32'd0);
    tick();
    check_eq("t6_req_edge6", {31'd0, pd_button_ns}, 32'd1);
    ticks(3);
    check_eq("t6_sen_edge9", {31'd0, ns_sensor}, 32'd0);
    tick();
    check_eq("t6_sen_edge10", {31'd0, ns_sensor}, 32'd1);
    ticks(2);
    check_eq("t6_recount", 32'(veh_count_ns), 32'd1);

    // Randomized traffic on both channels.
    foreach (run_b[i]) begin run_b[i] = 0; run_s[i] = 0; end
    repeat (5000) begin
      rand_drive();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
